// File: rtl/cv32e40x_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40x_pkg
//   Shared types for the cv32e40x pipeline slice used by the writeback stage.
//   - ex_wb_pipe_t : EX/WB pipeline register contents.
//   - ctrl_fsm_t   : controller outputs consumed by WB (kill_wb, halt_wb).
//   - wb_state_e   : writeback LSU-response buffer FSM states.
//   - lsu_rsp_t    : one LSU response (load data plus bus error).
// -----------------------------------------------------------------------------
package cv32e40x_pkg;

    localparam int unsigned REGFILE_ADDR_W = 5;

    typedef struct packed {
        logic                        instr_valid;
        logic                        lsu_en;
        logic                        rf_we;
        logic [REGFILE_ADDR_W-1:0]   rf_waddr;
        logic [31:0]                 rf_wdata;
    } ex_wb_pipe_t;

    typedef struct packed {
        logic kill_wb;
        logic halt_wb;
    } ctrl_fsm_t;

    typedef enum logic {
        WB_RUN  = 1'b0,
        WB_HOLD = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } lsu_rsp_t;

    localparam lsu_rsp_t LSU_RSP_RESET = '{rdata: 32'h0, err: 1'b0};

endpackage

// File: rtl/cv32e40x_wb_writeback.sv
// -----------------------------------------------------------------------------
// cv32e40x_wb_writeback
//   Writeback stage. Completes instructions from the EX/WB register, merges
//   LSU load data, drives the register-file write port (which doubles as the
//   WB forwarding path) and produces the wb_ready/wb_valid handshake.
//   A single-entry response buffer lets the LSU hand over its response even
//   while the controller halts WB or before the load reaches WB.
//
// Handshake: the LSU transfers a response on a cycle where lsu_valid_i is
//   high; WB only accepts it while lsu_ready_o is high, and the LSU must not
//   assert lsu_valid_i while lsu_ready_o is low. EX hands a new instruction to
//   WB on a cycle where wb_ready_o is high.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ex_wb_pipe_i      EX/WB pipeline register
//   ctrl_fsm_i        controller kill_wb / halt_wb
//   lsu_valid_i/rdata_i/err_i  LSU response
//   lsu_ready_o       WB can accept an LSU response (buffer empty)
//   rf_we/waddr/wdata_wb_o     register-file write port / forwarding value
//   lsu_exception_o   load/store bus error retires this cycle
//   wb_ready_o        WB can accept a new instruction from EX
//   wb_valid_o        instruction completes this cycle
//   retire_cnt_o      retired-instruction count
//
// Configuration:
//   CV32E40X_WB_RETIRE_CNT_EN  defined: 64-bit retire counter drives
//                              retire_cnt_o; undefined: retire_cnt_o = 0.
// -----------------------------------------------------------------------------
module cv32e40x_wb_writeback
    import cv32e40x_pkg::*;
#(
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  ex_wb_pipe_t          ex_wb_pipe_i,
    input  ctrl_fsm_t            ctrl_fsm_i,
    input  logic                 lsu_valid_i,
    input  logic [31:0]          lsu_rdata_i,
    input  logic                 lsu_err_i,
    output logic                 lsu_ready_o,
    output logic                 rf_we_wb_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_wb_o,
    output logic [31:0]          rf_wdata_wb_o,
    output logic                 lsu_exception_o,
    output logic                 wb_ready_o,
    output logic                 wb_valid_o,
    output logic [63:0]          retire_cnt_o
);

    wb_state_e state_q, state_d;
    lsu_rsp_t  buf_q, buf_d;

    logic        kill_wb;
    logic        halt_wb;
    logic        lsu_en;
    logic        instr_valid;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    assign kill_wb     = ctrl_fsm_i.kill_wb;
    assign halt_wb     = ctrl_fsm_i.halt_wb;
    assign lsu_en      = ex_wb_pipe_i.lsu_en;
    assign instr_valid = ex_wb_pipe_i.instr_valid && !kill_wb && !halt_wb;

    // Response source: live LSU signals in RUN, the buffered copy in HOLD.
    always_comb begin
        rsp_valid = lsu_valid_i;
        rsp_rdata = lsu_rdata_i;
        rsp_err   = lsu_err_i;
        if (state_q == WB_HOLD) begin
            rsp_valid = 1'b1;
            rsp_rdata = buf_q.rdata;
            rsp_err   = buf_q.err;
        end
    end

    // Handshake and register-file outputs.
    always_comb begin
        lsu_ready_o     = (state_q == WB_RUN);
        wb_valid_o      = instr_valid && (!lsu_en || rsp_valid);
        wb_ready_o      = kill_wb ||
                          (!halt_wb && (!(ex_wb_pipe_i.instr_valid && lsu_en) || rsp_valid));
        // A load without data yet, or with a bus error, must not write the RF.
        rf_we_wb_o      = ex_wb_pipe_i.rf_we && instr_valid &&
                          !(lsu_en && (!rsp_valid || rsp_err));
        rf_waddr_wb_o   = ex_wb_pipe_i.rf_waddr;
        rf_wdata_wb_o   = lsu_en ? rsp_rdata : ex_wb_pipe_i.rf_wdata;
        lsu_exception_o = wb_valid_o && lsu_en && rsp_err;
    end

    // Buffer FSM: next state and buffer contents.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        unique case (state_q)
            WB_RUN: begin
                // Response arrives but cannot be consumed now: park it.
                if (lsu_valid_i && (halt_wb || !ex_wb_pipe_i.instr_valid)) begin
                    state_d     = WB_HOLD;
                    buf_d.rdata = lsu_rdata_i;
                    buf_d.err   = lsu_err_i;
                end
            end
            WB_HOLD: begin
                // Consumed by the retiring load, or discarded by a kill.
                if (wb_valid_o || kill_wb) begin
                    state_d   = WB_RUN;
                    buf_d.err = 1'b0;
                end
            end
            default: begin
                state_d = WB_RUN;
                buf_d   = LSU_RSP_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_RUN;
            buf_q   <= LSU_RSP_RESET;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

`ifdef CV32E40X_WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    // Faulting loads complete but do not count as retired; wraps naturally.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wb_valid_o && !lsu_exception_o) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= 64'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`else
    assign retire_cnt_o = '0;
`endif

    // The LSU must not present a new response while one is buffered.
    a_no_rsp_in_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == WB_HOLD) |-> !lsu_valid_i
    );

    // The controller never kills a load that is still waiting on its response.
    a_no_kill_waiting_load: assert property (
        @(posedge clk) disable iff (!rst_n)
        ((state_q == WB_RUN) && ex_wb_pipe_i.instr_valid && lsu_en && !lsu_valid_i)
            |-> !kill_wb
    );

endmodule

// File: tb/tb_cv32e40x_wb_writeback.sv
module tb_cv32e40x_wb_writeback;
  import cv32e40x_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  ex_wb_pipe_t pipe;
  ctrl_fsm_t   ctrl;
  logic        lsu_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        lsu_exc;
  logic        wb_ready;
  logic        wb_valid;
  logic [63:0] retire_cnt;

  cv32e40x_wb_writeback #(.RF_ADDR_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_wb_pipe_i    (pipe),
    .ctrl_fsm_i      (ctrl),
    .lsu_valid_i     (lsu_valid),
    .lsu_rdata_i     (lsu_rdata),
    .lsu_err_i       (lsu_err),
    .lsu_ready_o     (lsu_ready),
    .rf_we_wb_o      (rf_we),
    .rf_waddr_wb_o   (rf_waddr),
    .rf_wdata_wb_o   (rf_wdata),
    .lsu_exception_o (lsu_exc),
    .wb_ready_o      (wb_ready),
    .wb_valid_o      (wb_valid),
    .retire_cnt_o    (retire_cnt)
  );

  // ---------------- scoreboard state ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Pending LSU responses held by WB: {rdata, err}. At most one entry.
  logic [32:0] exp_q[$];
  logic [63:0] cnt_m = 64'd0;

  // Outputs sampled by the last do_cycle, for directed literal checks.
  logic        s_lsu_ready, s_rf_we, s_lsu_exc, s_wb_ready, s_wb_valid;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [63:0] s_retire;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_retire();
`ifdef CV32E40X_WB_RETIRE_CNT_EN
    return cnt_m;
`else
    return 64'd0;
`endif
  endfunction

  // ---------------- driver + reference model ----------------
  task automatic apply_reset();
    pipe      = '0;
    ctrl      = '0;
    lsu_valid = 1'b0;
    lsu_rdata = 32'h0;
    lsu_err   = 1'b0;
    rst_n     = 1'b0;
    #2;
    exp_q.delete();
    cnt_m = 64'd0;
    check_eq("rst_lsu_ready", lsu_ready, 1'b1);
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_rf_we", rf_we, 1'b0);
    check_eq("rst_wb_ready", wb_ready, 1'b1);
    check_eq("rst_retire", retire_cnt, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_cycle(input logic pv, input logic lsu, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd,
                          input logic halt, input logic kill,
                          input logic lv, input logic [31:0] rd, input logic err);
    logic        have_buf, rv, re, iv;
    logic [31:0] rdat;
    logic        e_valid, e_ready, e_we, e_exc;
    logic [31:0] e_wdata;
    pipe.instr_valid = pv;
    pipe.lsu_en      = lsu;
    pipe.rf_we       = we;
    pipe.rf_waddr    = wa;
    pipe.rf_wdata    = wd;
    ctrl.halt_wb     = halt;
    ctrl.kill_wb     = kill;
    lsu_valid        = lv;
    lsu_rdata        = rd;
    lsu_err          = err;
    @(negedge clk);
    // A buffered response takes precedence over the live LSU inputs.
    have_buf = (exp_q.size() != 0);
    rv   = have_buf ? 1'b1 : lv;
    rdat = have_buf ? exp_q[0][32:1] : rd;
    re   = have_buf ? exp_q[0][0] : err;
    iv   = pv && !kill && !halt;
    e_valid = iv && (!lsu || rv);
    e_ready = kill || (!halt && (!(pv && lsu) || rv));
    e_we    = we && iv && !(lsu && (!rv || re));
    e_wdata = lsu ? rdat : wd;
    e_exc   = e_valid && lsu && re;

    s_lsu_ready = lsu_ready; s_rf_we = rf_we; s_lsu_exc = lsu_exc;
    s_wb_ready = wb_ready; s_wb_valid = wb_valid; s_waddr = rf_waddr;
    s_wdata = rf_wdata; s_retire = retire_cnt;

    check_eq("lsu_ready", lsu_ready, !have_buf);
    check_eq("wb_valid", wb_valid, e_valid);
    check_eq("wb_ready", wb_ready, e_ready);
    check_eq("rf_we", rf_we, e_we);
    check_eq("rf_waddr", rf_waddr, wa);
    check_eq("rf_wdata", rf_wdata, e_wdata);
    check_eq("lsu_exc", lsu_exc, e_exc);
    check_eq("retire_cnt", retire_cnt, exp_retire());

    // Advance the model to the next cycle.
    if (have_buf) begin
      if (e_valid || kill) void'(exp_q.pop_front());
    end else if (lv && (halt || !pv)) begin
      exp_q.push_back({rd, err});
    end
    if (e_valid && !e_exc) cnt_m = cnt_m + 64'd1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    apply_reset();

    // Ten retiring ALU ops plus one faulting load.
    for (int i = 0; i < 10; i++)
      do_cycle(1, 0, 1, 5'(i + 1), $urandom, 0, 0, 0, 32'h0, 0);
    do_cycle(1, 1, 1, 5'd3, 32'h0, 0, 0, 1, 32'h1111_2222, 1);
    do_cycle(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 0);
`ifdef CV32E40X_WB_RETIRE_CNT_EN
    check_eq("retire_after_11", s_retire, 64'd10);
`else
    check_eq("retire_after_11", s_retire, 64'd0);
`endif

    // ALU op completes in the same cycle.
    do_cycle(1, 0, 1, 5'd5, 32'h1234, 0, 0, 0, 32'h0, 0);
    check_eq("alu_we", s_rf_we, 1'b1);
    check_eq("alu_waddr", s_waddr, 5'd5);
    check_eq("alu_wdata", s_wdata, 32'h1234);
    check_eq("alu_valid", s_wb_valid, 1'b1);
    check_eq("alu_ready", s_wb_ready, 1'b1);

    // Load whose response arrives 3 cycles late.
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, 1, 1, 5'd7, 32'h0, 0, 0, 0, 32'h0, 0);
      check_eq("ld_wait_ready", s_wb_ready, 1'b0);
      check_eq("ld_wait_we", s_rf_we, 1'b0);
    end
    do_cycle(1, 1, 1, 5'd7, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    check_eq("ld_wdata", s_wdata, 32'hDEAD_BEEF);
    check_eq("ld_valid", s_wb_valid, 1'b1);

    // Response arrives while halted: buffered, then written on release.
    do_cycle(1, 1, 1, 5'd9, 32'h0, 1, 0, 1, 32'hA5A5_A5A5, 0);
    check_eq("halt_no_we", s_rf_we, 1'b0);
    do_cycle(1, 1, 1, 5'd9, 32'h0, 1, 0, 0, 32'h0, 0);
    check_eq("hold_lsu_ready", s_lsu_ready, 1'b0);
    do_cycle(1, 1, 1, 5'd9, 32'h0, 0, 0, 0, 32'h0, 0);
    check_eq("rel_we", s_rf_we, 1'b1);
    check_eq("rel_wdata", s_wdata, 32'hA5A5_A5A5);
    do_cycle(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 0);
    check_eq("rel_run", s_lsu_ready, 1'b1);

    // Faulting load.
    do_cycle(1, 1, 1, 5'd4, 32'h0, 0, 0, 1, 32'h5555_0000, 1);
    check_eq("err_valid", s_wb_valid, 1'b1);
    check_eq("err_exc", s_lsu_exc, 1'b1);
    check_eq("err_we", s_rf_we, 1'b0);

    // Early response buffered, then killed.
    do_cycle(0, 0, 0, 5'd0, 32'h0, 0, 0, 1, 32'h7777_8888, 0);
    do_cycle(1, 1, 1, 5'd2, 32'h0, 0, 1, 0, 32'h0, 0);
    check_eq("kill_valid", s_wb_valid, 1'b0);
    check_eq("kill_ready", s_wb_ready, 1'b1);
    do_cycle(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 0);
    check_eq("kill_run", s_lsu_ready, 1'b1);

    // Randomized traffic honouring the LSU/controller protocol.
    for (int i = 0; i < 1500; i++) begin
      logic pv, lsu, we, halt, kill, lv, err;
      pv   = ($urandom_range(0, 3) != 0);
      lsu  = $urandom_range(0, 1);
      we   = ($urandom_range(0, 3) != 0);
      halt = ($urandom_range(0, 3) == 0);
      lv   = (exp_q.size() == 0) && ($urandom_range(0, 2) == 0);
      kill = ($urandom_range(0, 7) == 0);
      if (kill && pv && lsu && (exp_q.size() == 0) && !lv) kill = 1'b0;
      err  = ($urandom_range(0, 5) == 0);
      do_cycle(pv, lsu, we, 5'($urandom), $urandom, halt, kill, lv, $urandom, err);
    end

    // Reset while a response is buffered.
    do_cycle(0, 0, 0, 5'd0, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 0);
    apply_reset();
    do_cycle(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 0);
    check_eq("post_rst_ready", s_lsu_ready, 1'b1);
    check_eq("post_rst_retire", s_retire, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40x_wb_writeback.md
Name: cv32e40x_wb_writeback

Overview:
- Writeback stage of the 4-stage pipeline; sits directly downstream of EX and consumes the EX/WB pipeline register (ex_wb_pipe_t).
- Completes loads by merging LSU response data and drives the register-file write port and WB forwarding path.
- Holds a single-entry LSU response buffer, so the LSU is released even while the controller halts WB.
- Produces wb_ready/wb_valid for the EX handshake and the controller.

Parameters:
- RF_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active-low.
- ex_wb_pipe_i  input  ex_wb_pipe_t  EX/WB pipeline register contents.
- ctrl_fsm_i  input  ctrl_fsm_t  controller outputs; uses kill_wb and halt_wb.
- lsu_valid_i  input  1  LSU response valid.
- lsu_rdata_i  input  32  LSU load data, already aligned and extended.
- lsu_err_i  input  1  LSU bus error on the response.
- lsu_ready_o  output  1  WB accepts an LSU response.
- rf_we_wb_o  output  1  register-file write enable.
- rf_waddr_wb_o  output  RF_ADDR_W  register-file write address.
- rf_wdata_wb_o  output  32  register-file write data; also the forwarding value to ID.
- lsu_exception_o  output  1  load/store bus error retires in WB this cycle.
- wb_ready_o  output  1  WB can accept a new instruction from EX.
- wb_valid_o  output  1  instruction completes/retires this cycle.
- retire_cnt_o  output  64  retired-instruction count; see Optional Feature.

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- instr_valid = ex_wb_pipe_i.instr_valid && !kill_wb && !halt_wb.
- FSM states:
  - RUN: no buffered response; lsu_ready_o = 1.
  - HOLD: response buffered in buf_rdata/buf_err; lsu_ready_o = 0.
- RUN -> HOLD: lsu_valid_i && (halt_wb || !ex_wb_pipe_i.instr_valid). Capture lsu_rdata_i and lsu_err_i in the buffer.
- HOLD -> RUN: wb_valid_o is asserted (buffered response consumed) or kill_wb is asserted (buffer discarded). Clear buf_err.
- Response selection: in RUN use the live lsu_valid_i/lsu_rdata_i/lsu_err_i; in HOLD use the buffer with rsp_valid = 1.
- wb_valid_o = instr_valid && (!lsu_en || rsp_valid). A non-LSU instruction completes in 0 added cycles.
- wb_ready_o = kill_wb || (!halt_wb && (!(ex_wb_pipe_i.instr_valid && lsu_en) || rsp_valid)).
- rf_we_wb_o = ex_wb_pipe_i.rf_we && instr_valid && !(lsu_en && (!rsp_valid || rsp_err)).
- rf_waddr_wb_o = ex_wb_pipe_i.rf_waddr.
- rf_wdata_wb_o = lsu_en ? rsp_rdata : ex_wb_pipe_i.rf_wdata.
- lsu_exception_o = wb_valid_o && lsu_en && rsp_err. The faulting load does not write the RF.
- Illegal instructions and other exceptions flagged upstream (illegal_insn, fetch err, MPU, trigger) set wb_valid_o normally; the controller handles them.
- Split LSU first half arrives with rf_we = 0 and completes without an RF write.
- Simultaneous lsu_valid_i and halt_wb in RUN: buffer the response; no RF write this cycle.
- lsu_valid_i while in HOLD is a protocol violation (assertion).
- kill_wb while a load in WB awaits a response in RUN is forbidden by the controller (assertion).
- Reset values (all outputs are combinational from registered state):
  - state = RUN, buffer = 0, lsu_ready_o = 1.
  - wb_valid_o = 0 and rf_we_wb_o = 0, because ex_wb_pipe resets instr_valid = 0.
  - retire_cnt_o = 0.
- Reset mid-HOLD discards the buffered response.

Optional Feature:
- Macro: CV32E40X_WB_RETIRE_CNT_EN.
- Defined: a 64-bit counter increments on every cycle with wb_valid_o && !lsu_exception_o. It wraps from 2^64-1 to 0 and drives retire_cnt_o.
- Undefined: no counter flops; retire_cnt_o tied to '0.

Decomposition:
- cv32e40x_pkg:
  - add wb_state_e {WB_RUN, WB_HOLD};
  - add lsu_rsp_t {rdata[31:0], err};
  - reuse ex_wb_pipe_t and ctrl_fsm_t.
- No sub-module. The FSM, buffer and muxing are one flat module of roughly 150-250 RTL lines.

Test Plan:
- ALU op: instr_valid = 1, rf_we = 1, waddr = 5, wdata = 0x1234 -> same cycle rf_we_wb_o = 1, waddr = 5, wdata = 0x1234, wb_valid_o = 1, wb_ready_o = 1.
- Load, response delayed 3 cycles:
  - wb_ready_o = 0 and rf_we_wb_o = 0 for 3 cycles;
  - then lsu_valid_i with rdata = 0xDEADBEEF -> rf_wdata_wb_o = 0xDEADBEEF, wb_valid_o = 1.
- halt_wb with lsu_valid_i (rdata = 0xA5A5A5A5):
  - state -> HOLD, lsu_ready_o = 0 next cycle, no RF write;
  - release halt -> RF write 0xA5A5A5A5, state -> RUN.
- Load with lsu_err_i = 1 -> wb_valid_o = 1, lsu_exception_o = 1, rf_we_wb_o = 0.
- kill_wb in HOLD -> buffer dropped, state RUN, wb_valid_o = 0, wb_ready_o = 1.
- With CV32E40X_WB_RETIRE_CNT_EN: 10 valid retires plus 1 faulting load -> retire_cnt_o = 10. Assert rst_n mid-run -> retire_cnt_o = 0.
